ifetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined DLX core, directly upstream of the decode/control logic.
- Owns the PC and drives a ready-based instruction-memory port.
- Presents the IF/ID pipeline register (instruction word plus PC+4) to decode.
- Accepts stall from the hazard unit and branch/jump redirects resolved in decode, computes targets, and squashes wrong-path fetches by injecting NOPs.

---
 rtl/dlx_pkg.sv | 27 ++
 rtl/ifetch_next_pc.sv | 38 +++
 rtl/ifetch_stage.sv | 191 +++++++++++++++++++
 tb/tb_ifetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_pkg.sv
// Shared DLX core types: NOP encoding, fetch FSM states and an
// immediate sign-extension helper.
package dlx_pkg;

    localparam logic [0:31] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_e;

    // 16-bit fields sit right-justified in [10:25]; sign bit is imm[10]
    function automatic logic [0:31] sext(
        input logic [0:25] imm,
        input logic        is_short
    );
        logic [0:31] r;
        if (is_short) begin
            r = {{16{imm[10]}}, imm[10:25]};
        end else begin
            r = {{6{imm[0]}}, imm};
        end
        return r;
    endfunction

endpackage

// File: rtl/ifetch_next_pc.sv
// Redirect decision and branch/jump target computation for the
// fetch stage (purely combinational).
module ifetch_next_pc
    import dlx_pkg::*;
(
    input  logic        stall,
    input  logic        if_valid,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        zero,
    input  logic [0:15] branch_imm,
    input  logic [0:25] jump_imm,
    input  logic [0:31] reg_target,
    input  logic [0:31] if_npc,
    output logic        redir,
    output logic [0:31] target
);

    logic        taken;
    logic [0:31] raw_target;

    always_comb begin
        taken = jump | jump_reg | (branch & zero) | (branch_ne & ~zero);
        redir = ~stall & if_valid & taken;
        if (jump_reg) begin
            raw_target = reg_target;
        end else if (jump) begin
            raw_target = if_npc + sext(jump_imm, 1'b0);
        end else begin
            raw_target = if_npc + sext({10'd0, branch_imm}, 1'b1);
        end
        // fetch addresses are always word aligned
        target = raw_target & 32'hFFFF_FFFC;
    end

endmodule

// File: rtl/ifetch_stage.sv
// DLX instruction-fetch stage: PC, imem handshake, skid buffer, IF/ID.
// Optional perf counters enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_stage
    import dlx_pkg::*;
#(
    parameter logic [0:31] RESET_PC  = 32'h00000000,
    parameter logic [0:31] NOP_INSTR = dlx_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        zero,
    input  logic [0:15] branch_imm,
    input  logic [0:25] jump_imm,
    input  logic [0:31] reg_target,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ready,
    input  logic [0:31] imem_rdata,
    output logic [0:31] if_instr,
    output logic [0:31] if_npc,
    output logic        if_valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [0:31] perf_fetched,
    output logic [0:31] perf_squashed,
    output logic [0:31] perf_stall_cyc
`endif
);

    state_e      state_q,     state_d;
    logic [0:31] pc_q,        pc_d;
    logic [0:31] drop_addr_q, drop_addr_d;
    logic [0:31] skid_q,      skid_d;
    logic [0:31] instr_q,     instr_d;
    logic [0:31] npc_q,       npc_d;
    logic        valid_q,     valid_d;

    logic        redir;
    logic [0:31] target;
    logic [0:31] pc_inc;
    logic [0:31] addr_sel;

    ifetch_next_pc u_next_pc (
        .stall      (stall),
        .if_valid   (valid_q),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .zero       (zero),
        .branch_imm (branch_imm),
        .jump_imm   (jump_imm),
        .reg_target (reg_target),
        .if_npc     (npc_q),
        .redir      (redir),
        .target     (target)
    );

    always_comb begin
        addr_sel  = (state_q == S_DROP) ? drop_addr_q : pc_q;
        imem_addr = addr_sel & 32'hFFFF_FFFC;
        imem_req  = rst_n & (state_q != S_HOLD);
        pc_inc    = pc_q + 32'd4;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        skid_d      = skid_q;
        instr_d     = instr_q;
        npc_d       = npc_q;
        valid_d     = valid_q;
        unique case (state_q)
            S_REQ: begin
                if (redir) begin
                    pc_d    = target;
                    instr_d = NOP_INSTR;
                    npc_d   = '0;
                    valid_d = 1'b0;
                    // keep the old address on the bus until memory answers
                    if (!imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = S_DROP;
                    end
                end else if (imem_ready && !stall) begin
                    instr_d = imem_rdata;
                    npc_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else if (imem_ready) begin
                    skid_d  = imem_rdata;
                    state_d = S_HOLD;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    npc_d   = '0;
                    valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    instr_d = skid_q;
                    npc_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (!stall) begin
                    instr_d = NOP_INSTR;
                    npc_d   = '0;
                    valid_d = 1'b0;
                end
                if (imem_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            skid_q      <= '0;
            instr_q     <= NOP_INSTR;
            npc_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            skid_q      <= skid_d;
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            valid_q     <= valid_d;
        end
    end

    assign if_instr = instr_q;
    assign if_npc   = npc_q;
    assign if_valid = valid_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [0:31] fetched_q,  fetched_d;
    logic [0:31] squashed_q, squashed_d;
    logic [0:31] stall_q,    stall_d;

    always_comb begin
        fetched_d  = fetched_q;
        squashed_d = squashed_q;
        stall_d    = stall_q;
        if (imem_req && imem_ready) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (redir) begin
            squashed_d = squashed_q + 32'd1;
        end
        if (stall) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q  <= '0;
            squashed_q <= '0;
            stall_q    <= '0;
        end else begin
            fetched_q  <= fetched_d;
            squashed_q <= squashed_d;
            stall_q    <= stall_d;
        end
    end

    assign perf_fetched   = fetched_q;
    assign perf_squashed  = squashed_q;
    assign perf_stall_cyc = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios followed by
// random traffic, all compared against a behavioural fetch model.
module tb_ifetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        zero = 1'b0;
    logic [0:15] branch_imm = '0;
    logic [0:25] jump_imm = '0;
    logic [0:31] reg_target = '0;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ready = 1'b0;
    logic [0:31] imem_rdata = '0;
    logic [0:31] if_instr;
    logic [0:31] if_npc;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    // behavioural model of the architectural fetch state
    logic [31:0] m_pc, m_drop_addr, m_skid, m_instr, m_npc;
    bit          m_valid, m_hold, m_drop;

    ifetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branch     (branch),
        .branch_ne  (branch_ne),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .zero       (zero),
        .branch_imm (branch_imm),
        .jump_imm   (jump_imm),
        .reg_target (reg_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_instr   (if_instr),
        .if_npc     (if_npc),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rdy, input logic [31:0] rdata);
        logic [31:0] tgt;
        bit          taken;
        if (!rst_n) begin
            m_pc = RST_PC; m_drop_addr = '0; m_skid = '0;
            m_instr = NOP; m_npc = '0; m_valid = 0;
            m_hold = 0; m_drop = 0;
            return;
        end
        taken = !stall && m_valid &&
                (jump || jump_reg || (branch && zero) || (branch_ne && !zero));
        if (jump_reg)  tgt = reg_target;
        else if (jump) tgt = m_npc + 32'($signed(jump_imm));
        else           tgt = m_npc + 32'($signed(branch_imm));
        tgt = tgt & ~32'h3;
        if (m_hold) begin
            if (!stall) begin
                m_instr = m_skid; m_npc = m_pc + 4; m_valid = 1;
                m_pc = m_pc + 4; m_hold = 0;
            end
        end else if (m_drop) begin
            if (!stall) begin
                m_instr = NOP; m_npc = '0; m_valid = 0;
            end
            if (rdy) m_drop = 0;
        end else if (taken) begin
            if (!rdy) begin
                m_drop = 1; m_drop_addr = m_pc;
            end
            m_pc = tgt; m_instr = NOP; m_npc = '0; m_valid = 0;
        end else if (rdy && !stall) begin
            m_instr = rdata; m_npc = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
        end else if (rdy) begin
            m_skid = rdata; m_hold = 1;
        end else if (!stall) begin
            m_instr = NOP; m_npc = '0; m_valid = 0;
        end
    endtask

    task automatic check_all();
        chk("req",   imem_req, rst_n && !m_hold);
        chk("addr",  imem_addr, m_drop ? m_drop_addr : m_pc);
        chk("instr", if_instr, m_instr);
        chk("npc",   if_npc, m_npc);
        chk("valid", if_valid, m_valid);
    endtask

    task automatic step(input bit st, input bit br, input bit bne,
                        input bit j, input bit jr, input bit z,
                        input logic [15:0] bi, input logic [25:0] ji,
                        input logic [31:0] rt, input bit rdy);
        stall = st; branch = br; branch_ne = bne;
        jump = j; jump_reg = jr; zero = z;
        branch_imm = bi; jump_imm = ji; reg_target = rt;
        imem_ready = rdy;
        imem_rdata = rdy ? imem_addr : $urandom;
        model_step(rdy, imem_rdata);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic seq(input bit st, input bit rdy);
        step(st, 0, 0, 0, 0, 0, '0, '0, '0, rdy);
    endtask

    initial begin
        rst_n = 1'b0;
        seq(0, 1);
        seq(0, 1);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_req", imem_req, 0);
        rst_n = 1'b1;
        #1;
        chk("req_after_rst", imem_req, 1);
        chk("addr_after_rst", imem_addr, RST_PC);

        // zero-wait sequential fetch
        seq(0, 1);
        chk("seq_i0", if_instr, 32'h0);
        chk("seq_n0", if_npc, 32'h4);
        seq(0, 1);
        chk("seq_i1", if_instr, 32'h4);
        chk("seq_a1", imem_addr, 32'h8);

        // stall lands on the beat for address 8
        seq(1, 1);
        chk("stall_i", if_instr, 32'h4);
        chk("stall_req", imem_req, 0);
        seq(1, 1);
        seq(0, 1);
        chk("unstall_i", if_instr, 32'h8);
        chk("unstall_a", imem_addr, 32'hC);
        seq(0, 1);
        chk("after_i", if_instr, 32'hC);

        // jr to 0xFC so that if_npc becomes 0x100
        step(0, 0, 0, 0, 1, 0, '0, '0, 32'hFC, 1);
        chk("jr_a", imem_addr, 32'hFC);
        seq(0, 1);
        chk("npc100", if_npc, 32'h100);
        step(0, 1, 0, 0, 0, 1, 16'hFFF0, '0, '0, 1);
        chk("br_a", imem_addr, 32'hF0);
        chk("br_bubble", if_valid, 0);
        seq(0, 1);
        chk("br_i", if_instr, 32'hF0);

        // bnez with zero=1 falls through, then jr to unaligned target
        step(0, 0, 1, 0, 0, 1, 16'h0040, '0, '0, 1);
        chk("bne_nt_i", if_instr, 32'hF4);
        chk("bne_nt_a", imem_addr, 32'hF8);
        step(0, 0, 0, 0, 1, 0, '0, '0, 32'h2003, 1);
        chk("jr_align", imem_addr, 32'h2000);
        seq(0, 1);

        // jump while memory inserts two wait states
        step(0, 0, 0, 1, 0, 0, '0, 26'h40, '0, 0);
        chk("drop_a0", imem_addr, 32'h2004);
        seq(0, 0);
        chk("drop_a1", imem_addr, 32'h2004);
        seq(0, 1);
        chk("drop_v", if_valid, 0);
        chk("drop_tgt", imem_addr, 32'h2044);
        seq(0, 1);
        chk("jmp_i", if_instr, 32'h2044);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 1) == 1,
                 16'($urandom), 26'($urandom),
                 $urandom, $urandom_range(0, 3) != 0);
        end

        // reset while parked in the skid buffer
        seq(0, 1);
        seq(0, 1);
        seq(1, 1);
        chk("hold_req", imem_req, 0);
        seq(1, 0);
        rst_n = 1'b0;
        seq(1, 0);
        chk("hrst_valid", if_valid, 0);
        chk("hrst_instr", if_instr, NOP);
        rst_n = 1'b1;
        #1;
        chk("hrst_addr", imem_addr, RST_PC);
        chk("hrst_req", imem_req, 1);
        seq(0, 1);
        chk("hrst_i0", if_instr, RST_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
